mirror_frame_loader: RTL

- Serial-to-parallel front end for the 2×HALF_W mirror-equality comparator.
- Accepts a bit stream through a valid/ready handshake and assembles one 2×HALF_W-bit frame.
- Presents the frame to the combinational comparator and registers its match verdict, with framing-error detection and a saturating match counter.
- Sits directly upstream of the comparator and consumes its single-bit output.

---
 rtl/mirror_pkg.sv | 20 ++
 rtl/mirror_frame_loader_if.sv | 31 +++
 rtl/mirror_shift_reg.sv | 23 ++
 rtl/mirror_frame_loader.sv | 116 +++++++++++
 4 files changed

// File: rtl/mirror_pkg.sv
// Shared types and constants for the mirror frame loader.
// Holds the FSM state enum, default frame sizing and the counter width helper.
package mirror_pkg;

  localparam int HALF_W_DEF = 20;
  localparam int FRAME_W    = 2 * HALF_W_DEF;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    DRAIN  = 2'd1,
    EVAL   = 2'd2,
    RESULT = 2'd3
  } state_t;

  // Wide enough to hold every bit index plus the one-past-end value seen on overrun.
  function automatic int cnt_width(input int frame_w);
    return $clog2(frame_w + 1);
  endfunction

endpackage

// File: rtl/mirror_frame_loader_if.sv
// Serial input stream, comparator hookup and result handshake of the frame loader.
// The slave modport is the loader's view; master is the environment driving it.
interface mirror_frame_loader_if #(
  parameter int HALF_W = 20,
  parameter int MCNT_W = 16
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic                  s_data;
  logic                  s_last;
  logic [2*HALF_W-1:0]   vec;
  logic                  vec_valid;
  logic                  match_in;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_match;
  logic                  res_err;
  logic [MCNT_W-1:0]     match_count;

  modport slave (
    input  s_valid, s_data, s_last, match_in, res_ready,
    output s_ready, vec, vec_valid, res_valid, res_match, res_err, match_count
  );

  modport master (
    output s_valid, s_data, s_last, match_in, res_ready,
    input  s_ready, vec, vec_valid, res_valid, res_match, res_err, match_count
  );

endinterface

// File: rtl/mirror_shift_reg.sv
// Frame register with indexed single-bit writes and a synchronous clear.
// Clear has priority over the write so a frame restart never keeps a stale bit.
module mirror_shift_reg #(
  parameter int W     = 40,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] idx,
  input  logic             bit_in,
  output logic [W-1:0]     q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (wr_en) begin
      q[idx] <= bit_in;
    end
  end

endmodule

// File: rtl/mirror_frame_loader.sv
// Serial-to-parallel loader feeding the mirror comparator and registering its verdict.
// Detects framing errors and keeps a saturating count of matched frames.
//
// state  | meaning
// LOAD   | collecting frame bits into vec
// DRAIN  | frame overran, discarding bits until s_last
// EVAL   | vec complete, sampling comparator verdict
// RESULT | verdict held until downstream takes it
module mirror_frame_loader
  import mirror_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF,
  parameter int CNT_W  = cnt_width(2 * HALF_W),
  parameter int MCNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mirror_frame_loader_if.slave  bus
);

  localparam int FRAME_LEN = 2 * HALF_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               err;
  logic               res_match;
  logic               res_err;
  logic [MCNT_W-1:0]  match_count;
  logic               accept;
  logic               vec_clr;
  logic               vec_wr;
  logic               good_verdict;

  assign bus.s_ready   = ((state == LOAD) || (state == DRAIN)) && !rst;
  assign accept        = bus.s_valid && bus.s_ready;
  assign bus.vec_valid = (state == EVAL);
  assign bus.res_valid = (state == RESULT);
  assign bus.res_match   = res_match;
  assign bus.res_err     = res_err;
  assign bus.match_count = match_count;

  assign good_verdict = bus.match_in && !err;

  // vec is cleared on reset, on a taken result, and when recovering from a bad state.
  assign vec_clr = rst
                || ((state == RESULT) && bus.res_ready)
                || !(state inside {LOAD, DRAIN, EVAL, RESULT});
  assign vec_wr  = (state == LOAD) && accept;

  mirror_shift_reg #(
    .W     (FRAME_LEN),
    .IDX_W (CNT_W)
  ) u_shift_reg (
    .clk    (clk),
    .clr    (vec_clr),
    .wr_en  (vec_wr),
    .idx    (cnt),
    .bit_in (bus.s_data),
    .q      (bus.vec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      cnt         <= '0;
      err         <= 1'b0;
      res_match   <= 1'b0;
      res_err     <= 1'b0;
      match_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_IDX) begin
              if (bus.s_last) begin
                state <= EVAL;
              end else begin
                err   <= 1'b1;
                state <= DRAIN;
              end
            end else if (bus.s_last) begin
              err   <= 1'b1;
              state <= EVAL;
            end
          end
        end
        DRAIN: begin
          if (accept && bus.s_last) state <= EVAL;
        end
        EVAL: begin
          res_match <= good_verdict;
          res_err   <= err;
          if (good_verdict && (match_count != '1)) begin
            match_count <= match_count + MCNT_W'(1);
          end
          state <= RESULT;
        end
        RESULT: begin
          if (bus.res_ready) begin
            state <= LOAD;
            cnt   <= '0;
            err   <= 1'b0;
          end
        end
        default: begin
          state <= LOAD;
          cnt   <= '0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
